// File: rtl/lcd_bus_decoder.sv
// Receive-side checker for a 4-bit character-LCD write bus: reassembles nibbles
// into bytes, follows the 3,3,3,2 power-on init and the DDRAM address, flags violations.
module lcd_bus_decoder #(
   parameter int MIN_E_HIGH = 12,
   parameter int ADDR_W     = 7
) (
   input  logic              CLK_50MHZ,
   input  logic              BTN_NORTH,
   input  logic [11:8]       SF_D,
   input  logic              LCD_E,
   input  logic              LCD_RS,
   input  logic              LCD_RW,
   output logic              byte_valid,
   output logic [7:0]        byte_data,
   output logic              byte_rs,
   output logic [ADDR_W-1:0] ddram_addr,
   output logic              init_done,
   output logic              timing_err,
   output logic              rw_err,
   output logic              seq_err
);

   localparam int CW = $clog2(MIN_E_HIGH + 1);
   localparam logic [CW-1:0] E_MIN = CW'(MIN_E_HIGH);

   typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, HI, LO} state_t;

   state_t          state_q;
   logic            e_r_q, e_q;
   logic [3:0]      d_r_q;
   logic            rs_r_q, rw_r_q;
   logic [3:0]      nib_q;
   logic            rs_q, rw_q;
   logic [CW-1:0]   e_cnt_q;
   logic [3:0]      up_q;
   logic            up_rs_q;
   logic            strobe;
   logic [7:0]      byte_d;

   assign strobe = e_q & ~e_r_q;
   assign byte_d = {up_q, nib_q};

   always_ff @(posedge CLK_50MHZ) begin
      if (BTN_NORTH) begin
         state_q    <= INIT0;
         e_r_q      <= 1'b0;
         e_q        <= 1'b0;
         d_r_q      <= '0;
         rs_r_q     <= 1'b0;
         rw_r_q     <= 1'b0;
         nib_q      <= '0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         e_cnt_q    <= '0;
         up_q       <= '0;
         up_rs_q    <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_rs    <= 1'b0;
         ddram_addr <= '0;
         init_done  <= 1'b0;
         timing_err <= 1'b0;
         rw_err     <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         e_r_q  <= LCD_E;
         d_r_q  <= SF_D;
         rs_r_q <= LCD_RS;
         rw_r_q <= LCD_RW;
         e_q    <= e_r_q;

         // Keep the bus values from the last high cycle of the strobe.
         if (e_r_q) begin
            nib_q <= d_r_q;
            rs_q  <= rs_r_q;
            rw_q  <= rw_r_q;
            if (e_cnt_q < E_MIN) e_cnt_q <= e_cnt_q + 1'b1;
         end else begin
            e_cnt_q <= '0;
         end

         byte_valid <= 1'b0;
         timing_err <= 1'b0;
         rw_err     <= 1'b0;
         seq_err    <= 1'b0;

         if (strobe) begin
            if (e_cnt_q < E_MIN) begin
               timing_err <= 1'b1;
            end else if (rw_q) begin
               rw_err <= 1'b1;
            end else begin
               case (state_q)
                  INIT0, INIT1, INIT2: begin
                     if (nib_q == 4'h3) begin
                        state_q <= state_t'(state_q + 3'd1);
                     end else begin
                        seq_err <= 1'b1;
                        state_q <= INIT0;
                     end
                  end
                  INIT3: begin
                     if (nib_q == 4'h2) begin
                        state_q   <= HI;
                        init_done <= 1'b1;
                     end else begin
                        seq_err <= 1'b1;
                        state_q <= (nib_q == 4'h3) ? INIT1 : INIT0;
                     end
                  end
                  HI: begin
                     up_q    <= nib_q;
                     up_rs_q <= rs_q;
                     state_q <= LO;
                  end
                  LO: begin
                     if (rs_q == up_rs_q) begin
                        byte_data  <= byte_d;
                        byte_rs    <= rs_q;
                        byte_valid <= 1'b1;
                        state_q    <= HI;
                        if (rs_q)
                           ddram_addr <= ddram_addr + 1'b1;
                        else if (byte_d == 8'h01 || byte_d == 8'h02 || byte_d == 8'h03)
                           ddram_addr <= '0;
                        else if (byte_d[7])
                           ddram_addr <= ADDR_W'(byte_d[6:0]);
                     end else begin
                        // RS mismatch: drop the pair, restart with this nibble as upper half.
                        seq_err <= 1'b1;
                        up_q    <= nib_q;
                        up_rs_q <= rs_q;
                     end
                  end
                  default: state_q <= INIT0;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: init sequence, byte assembly, address
// tracking, timing/RW/sequence errors and mid-byte reset.
module tb_lcd_bus_decoder;

   logic        clk = 1'b0;
   logic        btn = 1'b1;
   logic [11:8] sf_d = 4'h0;
   logic        e = 1'b0, rs = 1'b0, rw = 1'b0;
   logic        byte_valid, byte_rs, init_done, timing_err, rw_err, seq_err;
   logic [7:0]  byte_data;
   logic [6:0]  ddram_addr;

   int n_chk = 0, n_fail = 0;
   int n_bv, n_te, n_rw, n_se, bv_at;
   logic id1, id2;

   always #10 clk = ~clk;

   lcd_bus_decoder #(.MIN_E_HIGH(12), .ADDR_W(7)) dut (
      .CLK_50MHZ (clk),
      .BTN_NORTH (btn),
      .SF_D      (sf_d),
      .LCD_E     (e),
      .LCD_RS    (rs),
      .LCD_RW    (rw),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_rs   (byte_rs),
      .ddram_addr(ddram_addr),
      .init_done (init_done),
      .timing_err(timing_err),
      .rw_err    (rw_err),
      .seq_err   (seq_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One E pulse of 'hi' clocks, then a 4-cycle window tallying output pulses.
   task automatic strobe(input logic [3:0] nib, input logic r, input logic w, input int hi);
      @(negedge clk);
      sf_d = nib; rs = r; rw = w; e = 1'b1;
      repeat (hi) @(negedge clk);
      e = 1'b0; sf_d = ~nib; rs = ~r; rw = 1'b0;
      n_bv = 0; n_te = 0; n_rw = 0; n_se = 0; bv_at = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (byte_valid) begin n_bv++; bv_at = i; end
         if (timing_err) n_te++;
         if (rw_err) n_rw++;
         if (seq_err) n_se++;
         if (i == 1) id1 = init_done;
         if (i == 2) id2 = init_done;
      end
   endtask

   task automatic no_err(input string tag);
      chk({tag, "_te"}, n_te, 0);
      chk({tag, "_rw"}, n_rw, 0);
      chk({tag, "_se"}, n_se, 0);
   endtask

   task automatic byte_chk(input string tag, input logic [7:0] b, input logic r, input logic [6:0] a);
      strobe(b[7:4], r, 1'b0, 13);
      chk({tag, "_hi_nobv"}, n_bv, 0);
      strobe(b[3:0], r, 1'b0, 13);
      chk({tag, "_bv"}, n_bv, 1);
      chk({tag, "_data"}, byte_data, b);
      chk({tag, "_rs"}, byte_rs, r);
      chk({tag, "_addr"}, ddram_addr, a);
      no_err(tag);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_bv", byte_valid, 0);
      chk("rst_data", byte_data, 0);
      chk("rst_addr", ddram_addr, 0);
      chk("rst_init", init_done, 0);
      chk("rst_errs", {timing_err, rw_err, seq_err}, 0);
      btn = 1'b0;

      // Init sequence 3,3,3,2
      for (int k = 0; k < 3; k++) begin
         strobe(4'h3, 1'b0, 1'b0, 13);
         chk("init_pending", init_done, 0);
         no_err("init3");
      end
      strobe(4'h2, 1'b0, 1'b0, 13);
      chk("init_c1", id1, 0);
      chk("init_c2", id2, 1);
      chk("init_nobv", n_bv, 0);
      no_err("init2");

      // First data byte, pulse timing and width
      strobe(4'h4, 1'b1, 1'b0, 13);
      chk("b41_hi_nobv", n_bv, 0);
      strobe(4'h1, 1'b1, 1'b0, 13);
      chk("b41_bv", n_bv, 1);
      chk("b41_bv_at", bv_at, 2);
      chk("b41_data", byte_data, 8'h41);
      chk("b41_rs", byte_rs, 1);
      chk("b41_addr", ddram_addr, 7'h01);

      byte_chk("setC5", 8'hC5, 1'b0, 7'h45);
      byte_chk("d20", 8'h20, 1'b1, 7'h46);
      byte_chk("setFF", 8'hFF, 1'b0, 7'h7F);
      byte_chk("wrap", 8'h42, 1'b1, 7'h00);
      byte_chk("home", 8'h02, 1'b0, 7'h00);

      // Short E (5 and 11 clocks) rejected between nibbles; exactly 12 accepted
      strobe(4'h4, 1'b1, 1'b0, 13);
      strobe(4'h9, 1'b1, 1'b0, 5);
      chk("te5_pulse", n_te, 1);
      chk("te5_nobv", n_bv, 0);
      chk("te5_other", {n_rw[0], n_se[0]}, 0);
      strobe(4'h3, 1'b1, 1'b0, 12);
      chk("e12_bv", n_bv, 1);
      chk("e12_data", byte_data, 8'h43);
      chk("e12_addr", ddram_addr, 7'h01);

      strobe(4'h5, 1'b1, 1'b0, 13);
      strobe(4'h9, 1'b1, 1'b0, 11);
      chk("te11_pulse", n_te, 1);
      strobe(4'h7, 1'b1, 1'b1, 13);
      chk("rw_pulse", n_rw, 1);
      chk("rw_nobv", n_bv, 0);
      chk("rw_other", {n_te[0], n_se[0]}, 0);
      strobe(4'h6, 1'b1, 1'b0, 13);
      chk("rw_after_data", byte_data, 8'h56);
      chk("rw_after_addr", ddram_addr, 7'h02);

      // RS change between nibbles
      strobe(4'h6, 1'b0, 1'b0, 13);
      strobe(4'h7, 1'b1, 1'b0, 13);
      chk("seq_pulse", n_se, 1);
      chk("seq_nobv", n_bv, 0);
      strobe(4'h8, 1'b1, 1'b0, 13);
      chk("seq_bv", n_bv, 1);
      chk("seq_data", byte_data, 8'h78);
      chk("seq_rs", byte_rs, 1);
      chk("seq_addr", ddram_addr, 7'h03);

      // Reset between nibbles
      strobe(4'h4, 1'b1, 1'b0, 13);
      @(negedge clk); btn = 1'b1;
      repeat (2) @(negedge clk);
      btn = 1'b0;
      chk("mrst_init", init_done, 0);
      chk("mrst_data", byte_data, 0);
      chk("mrst_addr", ddram_addr, 0);
      chk("mrst_rs", byte_rs, 0);
      for (int k = 0; k < 3; k++) begin
         strobe(4'h3, 1'b0, 1'b0, 13);
         chk("reinit_pending", init_done, 0);
         no_err("reinit");
      end
      strobe(4'h2, 1'b0, 1'b0, 13);
      chk("reinit_done", init_done, 1);
      byte_chk("post", 8'h31, 1'b1, 7'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
